// File: rtl/fp16_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp16_pkg
// Brief    : Shared binary16 constants, FSM state type and flag bit indices.
// Revision : 1.0 - initial release
// ============================================================================
package fp16_pkg;

    localparam int          BIAS    = 15;
    localparam int          EXP_MAX = 31;
    localparam logic [15:0] QNAN    = 16'h7E00;
    localparam int          MANT_W  = 11;
    localparam int          QUOT_W  = 13;

    // Bit positions inside the {invalid, div_by_zero, overflow, underflow} word
    localparam int FLAG_INVALID   = 3;
    localparam int FLAG_DIV_ZERO  = 2;
    localparam int FLAG_OVERFLOW  = 1;
    localparam int FLAG_UNDERFLOW = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UNPACK = 2'd1,
        DIVIDE = 2'd2,
        ROUND  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/fp16_unpack.sv
`default_nettype none
// ============================================================================
// Module   : fp16_unpack
// Brief    : Splits a binary16 word into fields and classifies it.
// Revision : 1.0 - initial release
// ============================================================================
module fp16_unpack
    import fp16_pkg::*;
(
    input  logic [15:0]       word_i,
    output logic              sign_o,
    output logic [4:0]        exp_o,
    output logic [MANT_W-1:0] mant_o,
    output logic              is_zero_o,
    output logic              is_inf_o,
    output logic              is_nan_o
);

    // Exponent zero counts as zero, so subnormals are flushed here.
    always_comb begin
        sign_o    = word_i[15];
        exp_o     = word_i[14:10];
        mant_o    = {(word_i[14:10] != 5'd0), word_i[9:0]};
        is_zero_o = (word_i[14:10] == 5'd0);
        is_inf_o  = (word_i[14:10] == 5'h1F) && (word_i[9:0] == 10'd0);
        is_nan_o  = (word_i[14:10] == 5'h1F) && (word_i[9:0] != 10'd0);
    end

endmodule
`default_nettype wire

// File: rtl/fp16_divider.sv
`default_nettype none
// ============================================================================
// Module   : fp16_divider
// Brief    : Sequential binary16 divider, one restoring quotient bit per clock;
//            out_Flags exists only when FP16_DIV_STATUS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module fp16_divider
    import fp16_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] in_A,
    input  logic [15:0] in_B,
    input  logic        in_En,
    output logic [15:0] out_Out,
    output logic        out_Ready,
    output logic        out_Busy
`ifdef FP16_DIV_STATUS_EN
    ,
    output logic [3:0]  out_Flags
`endif
);

    localparam logic signed [6:0] BIAS_S    = 7'(BIAS);
    localparam logic signed [6:0] EXP_MAX_S = 7'(EXP_MAX);

    state_t              state_q, state_d;
    logic [15:0]         a_q, a_d, b_q, b_d;
    logic                sign_q, sign_d;
    logic signed [6:0]   exp_q, exp_d;
    logic [MANT_W:0]     rem_q, rem_d;
    logic [QUOT_W-1:0]   quot_q, quot_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                spec_q, spec_d;
    logic [15:0]         spec_val_q, spec_val_d;
    logic [15:0]         out_q, out_d;
    logic                ready_q, ready_d;
`ifdef FP16_DIV_STATUS_EN
    logic [3:0]          flags_q, flags_d, spec_flags_q, spec_flags_d;
`endif

    logic                ua_sign, ub_sign, ua_zero, ub_zero, ua_inf, ub_inf, ua_nan, ub_nan;
    logic [4:0]          ua_exp, ub_exp;
    logic [MANT_W-1:0]   ua_mant, ub_mant;

    fp16_unpack u_unpack_a (
        .word_i(a_q), .sign_o(ua_sign), .exp_o(ua_exp), .mant_o(ua_mant),
        .is_zero_o(ua_zero), .is_inf_o(ua_inf), .is_nan_o(ua_nan)
    );

    fp16_unpack u_unpack_b (
        .word_i(b_q), .sign_o(ub_sign), .exp_o(ub_exp), .mant_o(ub_mant),
        .is_zero_o(ub_zero), .is_inf_o(ub_inf), .is_nan_o(ub_nan)
    );

    // Restoring step: the partial remainder stays below twice the divisor.
    logic                w_ge;
    logic [MANT_W-1:0]   w_sub;
    assign w_ge  = (rem_q >= {1'b0, ub_mant});
    assign w_sub = MANT_W'(rem_q - {1'b0, ub_mant});

    logic [MANT_W-2:0]   w_frac, w_frac_f;
    logic [MANT_W-1:0]   w_frac_r;
    logic                w_guard, w_sticky, w_round_up, w_ovf, w_unf;
    logic signed [6:0]   w_exp_n, w_exp_f;
    logic [15:0]         w_result;

    always_comb begin
        if (quot_q[QUOT_W-1]) begin
            w_frac   = quot_q[QUOT_W-2:2];
            w_guard  = quot_q[1];
            w_sticky = quot_q[0] | (|rem_q);
            w_exp_n  = exp_q;
        end else begin
            w_frac   = quot_q[QUOT_W-3:1];
            w_guard  = quot_q[0];
            w_sticky = |rem_q;
            w_exp_n  = exp_q - 7'sd1;
        end
        w_round_up = w_guard & (w_sticky | w_frac[0]);
        // A carry out of the fraction leaves it at zero, i.e. mantissa 1.0.
        w_frac_r   = {1'b0, w_frac} + {{(MANT_W-1){1'b0}}, w_round_up};
        w_frac_f   = w_frac_r[MANT_W-2:0];
        w_exp_f    = w_exp_n + (w_frac_r[MANT_W-1] ? 7'sd1 : 7'sd0);
        w_ovf      = (w_exp_f >= EXP_MAX_S);
        w_unf      = (w_exp_f <= 7'sd0);
        if (w_ovf) begin
            w_result = {sign_q, 5'h1F, 10'h000};
        end else if (w_unf) begin
            w_result = {sign_q, 15'h0000};
        end else begin
            w_result = {sign_q, w_exp_f[4:0], w_frac_f};
        end
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        sign_d     = sign_q;
        exp_d      = exp_q;
        rem_d      = rem_q;
        quot_d     = quot_q;
        cnt_d      = cnt_q;
        spec_d     = spec_q;
        spec_val_d = spec_val_q;
        out_d      = out_q;
        ready_d    = 1'b0;
`ifdef FP16_DIV_STATUS_EN
        flags_d      = flags_q;
        spec_flags_d = spec_flags_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_En) begin
                    a_d     = in_A;
                    b_d     = in_B;
                    state_d = UNPACK;
                end
            end
            UNPACK: begin
                sign_d     = ua_sign ^ ub_sign;
                exp_d      = $signed({2'b00, ua_exp}) - $signed({2'b00, ub_exp}) + BIAS_S;
                rem_d      = {1'b0, ua_mant};
                quot_d     = '0;
                cnt_d      = 4'd0;
                spec_d     = 1'b1;
                spec_val_d = {ua_sign ^ ub_sign, 15'h0000};
`ifdef FP16_DIV_STATUS_EN
                spec_flags_d = 4'b0000;
`endif
                if (ua_nan || ub_nan || (ua_zero && ub_zero) || (ua_inf && ub_inf)) begin
                    spec_val_d = QNAN;
`ifdef FP16_DIV_STATUS_EN
                    spec_flags_d[FLAG_INVALID] = 1'b1;
`endif
                end else if (ua_inf) begin
                    spec_val_d = {ua_sign ^ ub_sign, 5'h1F, 10'h000};
                end else if (ub_zero) begin
                    spec_val_d = {ua_sign ^ ub_sign, 5'h1F, 10'h000};
`ifdef FP16_DIV_STATUS_EN
                    spec_flags_d[FLAG_DIV_ZERO] = 1'b1;
`endif
                end else if (!(ub_inf || ua_zero)) begin
                    spec_d = 1'b0;
                end
                state_d = DIVIDE;
            end
            DIVIDE: begin
                quot_d = {quot_q[QUOT_W-2:0], w_ge};
                rem_d  = w_ge ? {w_sub, 1'b0} : {rem_q[MANT_W-1:0], 1'b0};
                if (cnt_q == 4'(QUOT_W - 1)) begin
                    cnt_d   = 4'd0;
                    state_d = ROUND;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ROUND: begin
                out_d   = spec_q ? spec_val_q : w_result;
                ready_d = 1'b1;
`ifdef FP16_DIV_STATUS_EN
                flags_d = spec_q ? spec_flags_q : {2'b00, w_ovf, w_unf};
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            sign_q     <= 1'b0;
            exp_q      <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            cnt_q      <= 4'd0;
            spec_q     <= 1'b0;
            spec_val_q <= '0;
            out_q      <= 16'h0000;
            ready_q    <= 1'b0;
`ifdef FP16_DIV_STATUS_EN
            flags_q      <= 4'b0000;
            spec_flags_q <= 4'b0000;
`endif
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sign_q     <= sign_d;
            exp_q      <= exp_d;
            rem_q      <= rem_d;
            quot_q     <= quot_d;
            cnt_q      <= cnt_d;
            spec_q     <= spec_d;
            spec_val_q <= spec_val_d;
            out_q      <= out_d;
            ready_q    <= ready_d;
`ifdef FP16_DIV_STATUS_EN
            flags_q      <= flags_d;
            spec_flags_q <= spec_flags_d;
`endif
        end
    end

    assign out_Out   = out_q;
    assign out_Ready = ready_q;
    assign out_Busy  = (state_q != IDLE);
`ifdef FP16_DIV_STATUS_EN
    assign out_Flags = flags_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fp16_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp16_divider
// Brief    : Self-checking bench for fp16_divider (vector table + scoreboard).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp16_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_En;
    logic [15:0] in_A, in_B;
    logic [15:0] out_Out;
    logic        out_Ready, out_Busy;
`ifdef FP16_DIV_STATUS_EN
    logic [3:0]  out_Flags;
`endif

    typedef struct { logic [15:0] a; logic [15:0] b; logic [15:0] q; logic [3:0] f; } vec_t;
    typedef struct { logic [15:0] q; logic [3:0] f; int t; } exp_t;

    localparam int NVEC = 16;
    vec_t  vecs[NVEC];
    exp_t  sb[$];
    exp_t  mon_e;
    int    n_checks = 0;
    int    n_fail   = 0;
    int    edge_cnt = 0;
    int    ready_cnt = 0;
    int    rc;
    logic  prev_ready = 1'b0;
    logic  prev_busy  = 1'b0;

    always #5 clk = ~clk;

    fp16_divider dut (
        .clk       (clk),
        .rst       (rst),
        .in_A      (in_A),
        .in_B      (in_B),
        .in_En     (in_En),
        .out_Out   (out_Out),
        .out_Ready (out_Ready),
        .out_Busy  (out_Busy)
`ifdef FP16_DIV_STATUS_EN
        ,
        .out_Flags (out_Flags)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [15:0] q, input logic [3:0] f);
        exp_t e;
        e.q = q;
        e.f = f;
        e.t = edge_cnt;
        sb.push_back(e);
    endtask

    task automatic wait_done();
        int i = 0;
        while (i < 60 && (out_Busy || sb.size() != 0)) begin
            @(negedge clk);
            i++;
        end
        check("op_completed_pending", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] q, input logic [3:0] f);
        @(negedge clk);
        in_A  = a;
        in_B  = b;
        in_En = 1'b1;
        @(posedge clk);
        #1;
        push_exp(q, f);
        check("busy_after_accept", 32'(out_Busy), 32'd1);
        @(negedge clk);
        in_En = 1'b0;
        wait_done();
    endtask

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Scoreboard side: every result pulse must match the oldest pending operation.
    always @(posedge clk) begin
        #1;
        if (out_Ready) begin
            ready_cnt++;
            check("ready_single_cycle", 32'(prev_ready), 32'd0);
            check("busy_before_ready", 32'(prev_busy), 32'd1);
            check("busy_clear_at_ready", 32'(out_Busy), 32'd0);
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_ready: out_Out 0x%h with no pending operation", out_Out);
            end else begin
                mon_e = sb.pop_front();
                check("result", 32'(out_Out), 32'(mon_e.q));
                check("latency", 32'(edge_cnt - mon_e.t), 32'd15);
`ifdef FP16_DIV_STATUS_EN
                check("flags", 32'(out_Flags), 32'(mon_e.f));
`endif
            end
        end
        prev_ready = out_Ready;
        prev_busy  = out_Busy;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst   = 1'b1;
        in_En = 1'b0;
        in_A  = 16'h0000;
        in_B  = 16'h0000;

        // {a, b, expected quotient, expected {invalid, div0, ovf, unf}}
        vecs[0]  = '{16'h4600, 16'h4000, 16'h4200, 4'b0000};
        vecs[1]  = '{16'h3C00, 16'h4200, 16'h3555, 4'b0000};
        vecs[2]  = '{16'h57B7, 16'hD7B7, 16'hBC00, 4'b0000};
        vecs[3]  = '{16'h4500, 16'h4200, 16'h3EAB, 4'b0000};
        vecs[4]  = '{16'hC500, 16'h4200, 16'hBEAB, 4'b0000};
        vecs[5]  = '{16'h3C00, 16'h0000, 16'h7C00, 4'b0100};
        vecs[6]  = '{16'h3C00, 16'h8000, 16'hFC00, 4'b0100};
        vecs[7]  = '{16'h0000, 16'h0000, 16'h7E00, 4'b1000};
        vecs[8]  = '{16'hFC00, 16'h4000, 16'hFC00, 4'b0000};
        vecs[9]  = '{16'h7BFF, 16'h3800, 16'h7C00, 4'b0010};
        vecs[10] = '{16'h0400, 16'h4000, 16'h0000, 4'b0001};
        vecs[11] = '{16'h7E00, 16'h3C00, 16'h7E00, 4'b1000};
        vecs[12] = '{16'h7C00, 16'h7C00, 16'h7E00, 4'b1000};
        vecs[13] = '{16'h3C00, 16'h7C00, 16'h0000, 4'b0000};
        vecs[14] = '{16'h0000, 16'hC000, 16'h8000, 4'b0000};
        vecs[15] = '{16'h0200, 16'h3C00, 16'h0000, 4'b0000};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_out", 32'(out_Out), 32'h0);
        check("reset_ready", 32'(out_Ready), 32'd0);
        check("reset_busy", 32'(out_Busy), 32'd0);
`ifdef FP16_DIV_STATUS_EN
        check("reset_flags", 32'(out_Flags), 32'd0);
`endif

        // rst and in_En on the same edge: rst wins
        in_A  = 16'h4600;
        in_B  = 16'h4000;
        in_En = 1'b1;
        @(posedge clk);
        #1;
        check("rst_beats_en_busy", 32'(out_Busy), 32'd0);
        @(negedge clk);
        rst   = 1'b0;
        in_En = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].f);
        end

        // in_En held high: second accept lands 16 edges after the first
        @(negedge clk);
        in_A  = 16'h4600;
        in_B  = 16'h4000;
        in_En = 1'b1;
        @(posedge clk);
        #1;
        push_exp(16'h4200, 4'b0000);
        in_A = 16'h4500;
        in_B = 16'h4200;
        repeat (16) @(posedge clk);
        #1;
        push_exp(16'h3EAB, 4'b0000);
        check("held_en_reaccept_busy", 32'(out_Busy), 32'd1);
        @(negedge clk);
        in_En = 1'b0;
        wait_done();

        // in_En pulsed while busy is ignored
        rc = ready_cnt;
        @(negedge clk);
        in_A  = 16'h4600;
        in_B  = 16'h4000;
        in_En = 1'b1;
        @(posedge clk);
        #1;
        push_exp(16'h4200, 4'b0000);
        @(negedge clk);
        in_En = 1'b0;
        repeat (4) @(negedge clk);
        in_A  = 16'h3C00;
        in_B  = 16'h0000;
        in_En = 1'b1;
        @(negedge clk);
        in_En = 1'b0;
        wait_done();
        repeat (20) @(negedge clk);
        check("en_ignored_ready_count", 32'(ready_cnt - rc), 32'd1);
        check("en_ignored_out_held", 32'(out_Out), 32'h4200);
        check("en_ignored_idle", 32'(out_Busy), 32'd0);

        // rst sampled at divide iteration 5 (accept edge + 7)
        @(negedge clk);
        in_A  = 16'h3C00;
        in_B  = 16'h4200;
        in_En = 1'b1;
        @(posedge clk);
        #1;
        push_exp(16'h3555, 4'b0000);
        rc = ready_cnt;
        @(negedge clk);
        in_En = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_abort_busy", 32'(out_Busy), 32'd0);
        check("rst_abort_out", 32'(out_Out), 32'h0);
        check("rst_abort_ready", 32'(out_Ready), 32'd0);
`ifdef FP16_DIV_STATUS_EN
        check("rst_abort_flags", 32'(out_Flags), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("rst_abort_no_ready", 32'(ready_cnt - rc), 32'd0);
        check("rst_abort_out_held", 32'(out_Out), 32'h0);
        sb.delete();

        run_op(16'h4600, 16'h4000, 16'h4200, 4'b0000);
        run_op(16'h7BFF, 16'h3800, 16'h7C00, 4'b0010);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
